// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: NOP encoding, state encoding
// and default payload field offsets.
package pipe_pkg;

  localparam logic [31:0] INST_NOP = 32'h00000013;

  localparam int unsigned INS_LSB  = 0;
  localparam int unsigned ADDR_LSB = 32;
  localparam int unsigned RS1_LSB  = 64;
  localparam int unsigned RS2_LSB  = 96;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot with valid bit; set returns it to the idle payload and wins over load.
module pipe_entry #(
  parameter int unsigned     DW      = 128,
  parameter logic [DW-1:0]   SET_VAL = '0
) (
  input  logic          clk_i,
  input  logic          set_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (set_i) begin
      valid_d = 1'b0;
      data_d  = SET_VAL;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, valid/ready flow control,
// flush/hold and saturating flush/stall event counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned   DW      = 128,
  parameter logic [DW-1:0] SET_VAL = {{(DW - 32){1'b0}}, INST_NOP},
  parameter int unsigned   CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [DW-1:0]    up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [DW-1:0]    dn_data_o,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  logic          main_valid, skid_valid;
  logic [DW-1:0] main_data, skid_data, main_din;
  logic          main_set, main_load, skid_set, skid_load;
  logic          up_acc, dn_acc;

  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Hold masks both handshakes combinationally, so nothing moves while it is high.
  assign up_ready_o = !skid_valid && !hold_i;
  assign dn_valid_o = main_valid && !hold_i;
  assign dn_data_o  = main_data;

  assign up_acc = up_valid_i && up_ready_o && !flush_i;
  assign dn_acc = dn_valid_o && dn_ready_i && !flush_i;

  always_comb begin
    state_d   = state_q;
    main_set  = 1'b0;
    main_load = 1'b0;
    skid_set  = 1'b0;
    skid_load = 1'b0;
    main_din  = (state_q == StFull) ? skid_data : up_data_i;
    if (rst || flush_i) begin
      state_d  = StEmpty;
      main_set = 1'b1;
      skid_set = 1'b1;
    end else if (!hold_i) begin
      unique case (state_q)
        StEmpty: begin
          if (up_acc) begin
            main_load = 1'b1;
            state_d   = StBusy;
          end
        end
        StBusy: begin
          if (up_acc && dn_acc) begin
            main_load = 1'b1;
          end else if (up_acc) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end else if (dn_acc) begin
            main_set = 1'b1;
            state_d  = StEmpty;
          end
        end
        StFull: begin
          // Skid content always moves into main before any new beat is taken.
          if (dn_acc) begin
            main_load = 1'b1;
            skid_set  = 1'b1;
            state_d   = StBusy;
          end
        end
        default: begin
          state_d  = StEmpty;
          main_set = 1'b1;
          skid_set = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      flush_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (flush_i && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CntOne;
      end
      if (main_valid && !flush_i && (hold_i || !dn_ready_i) && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    flush_cnt_q <= flush_cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign flush_cnt_o = flush_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  pipe_entry #(
    .DW      (DW),
    .SET_VAL (SET_VAL)
  ) u_main (
    .clk_i   (clk),
    .set_i   (main_set),
    .load_i  (main_load),
    .data_i  (main_din),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  pipe_entry #(
    .DW      (DW),
    .SET_VAL (SET_VAL)
  ) u_skid (
    .clk_i   (clk),
    .set_i   (skid_set),
    .load_i  (skid_load),
    .data_i  (up_data_i),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register with a two-entry skid buffer, for the decode-to-execute and later stage boundaries.
- Adds valid/ready flow control on both sides, so a stalled consumer no longer drops or duplicates instructions.
- Keeps the existing flush (jump) and global hold semantics.
- Adds saturating flush and stall event counters for performance monitoring.

Parameters:
- DW, 128: payload width. Default packs {rs2_data, rs1_data, ins_addr, ins}, with ins in [31:0].
- SET_VAL, {96'b0, 32'h00000013}: payload presented when the stage is empty, reset or flushed. The ins field is NOP.
- CNT_W, 16: width of each event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- up_valid_i  in  1  upstream beat valid.
- up_ready_o  out  1  stage can accept a beat.
- up_data_i  in  DW  upstream payload.
- dn_valid_o  out  1  stage presents a valid beat.
- dn_ready_i  in  1  downstream accepts the beat.
- dn_data_o  out  DW  payload to downstream.
- flush_i  in  1  jump/redirect; kill all held beats.
- hold_i  in  1  global pipeline hold.
- flush_cnt_o  out  CNT_W  count of flush cycles.
- stall_cnt_o  out  CNT_W  count of cycles a valid beat was held back.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - main and skid entries invalid; state EMPTY.
  - dn_valid_o=0; dn_data_o=SET_VAL.
  - up_ready_o=1 (hold_i low); both counters 0.
- Storage: main entry (drives dn_data_o) and skid entry. Each entry has its own valid bit. Any invalid entry holds SET_VAL.
- Handshakes:
  - up_acc = up_valid_i & up_ready_o & !flush_i.
  - dn_acc = dn_valid_o & dn_ready_i & !flush_i.
- Output masking:
  - up_ready_o = !skid_valid & !hold_i.
  - dn_valid_o = main_valid & !hold_i.
  - The hold mask is combinational, so no transfer can occur on either side during hold.
- Latency: 1 cycle from up_acc to dn_valid_o. Sustains 1 beat/cycle while dn_ready_i=1.
- State machine:
  - EMPTY:
    - up_acc: main<=up_data_i, go to BUSY.
  - BUSY (main valid):
    - up_acc & dn_acc: main<=up_data_i, stay BUSY.
    - up_acc only: skid<=up_data_i, go to FULL.
    - dn_acc only: main<=SET_VAL, go to EMPTY.
    - neither: stay BUSY.
  - FULL (both valid; up_ready_o=0):
    - dn_acc: main<=skid, skid<=SET_VAL, go to BUSY.
    - otherwise: stay FULL.
- Ordering: beats leave strictly in arrival order. Skid content is never overtaken.
- Flush:
  - Priority: flush_i > hold_i > handshakes.
  - In a flush_i=1 cycle, next state is EMPTY and both entries are set to SET_VAL.
  - Any upstream beat offered in that cycle is dropped.
  - up_ready_o=1 the following cycle if hold_i=0.
- Hold:
  - With flush_i=0 and hold_i=1, state and entries are frozen.
  - When hold_i deasserts, the same beat is presented again: no loss, no duplication.
- Reset mid-operation: rst overrides flush/hold. Valid beats are discarded and the counters clear.
- flush_cnt_o: +1 on every cycle with flush_i=1.
- stall_cnt_o: +1 on every cycle with main_valid=1, flush_i=0, and either hold_i=1 or dn_ready_i=0.
- Both counters saturate at all-ones (no wrap).

Decomposition:
- Shared package pipe_pkg holds:
  - INST_NOP = 32'h00000013.
  - state encoding EMPTY=2'd0, BUSY=2'd1, FULL=2'd2 (2'd3 illegal; treat as EMPTY).
  - default payload field offsets (INS_LSB=0, ADDR_LSB=32, RS1_LSB=64, RS2_LSB=96).
- One natural sub-module: pipe_entry.
  - A DW-wide register with valid bit, load enable and synchronous set-to-SET_VAL.
  - Instantiated twice (main, skid).
- Counters stay inline.

Test Plan:
- Reset: assert rst for 2 cycles with up_valid_i=1 and data 0xAAAA… → dn_valid_o=0, dn_data_o=SET_VAL (ins=0x00000013), up_ready_o=1, counters=0.
- Streaming: dn_ready_i=1, send 8 beats with ins=1..8 back-to-back → ins 1..8 appear on consecutive cycles, first one 1 cycle after accept; up_ready_o stays 1.
- Backpressure: send ins=0x10, 0x11, 0x12 with dn_ready_i=0 → after 2 accepts up_ready_o=0 and 0x12 is held upstream; stall_cnt_o increments each cycle. Raising dn_ready_i delivers 0x10, 0x11, 0x12 in order.
- Flush in FULL: fill both entries, assert flush_i for 1 cycle with up_valid_i=1 → next cycle dn_valid_o=0, dn_data_o ins=0x00000013, offered beat dropped, flush_cnt_o=1.
- Hold in BUSY: main holds ins=0x20, dn_ready_i=1, hold_i=1 for 3 cycles → dn_valid_o=0, up_ready_o=0, stall_cnt_o+=3. After release, 0x20 is delivered exactly once.
- Flush+hold and saturation: flush_i=1 with hold_i=1 → EMPTY (flush wins). With CNT_W=4, 20 flush cycles → flush_cnt_o=4'hF.
